fsm_ex_control: RTL and testbench

//  Exposure/readout sequencer for the pixel-array camera core; one FSM with three top-level states.
//  On Init: ends the pixel erase, exposes the array and pulses Start to launch the external exposure timer.
//  On the timer's Ovf5: runs a fixed two-row readout sequence (NRE_1 row, then NRE_2 row), each row with an ADC strobe.

---
 rtl/fsm_ex_control.sv | 106 ++++++++++
 tb/tb_fsm_ex_control.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fsm_ex_control.sv
// Exposure/readout sequencer: IDLE -> EXPOSE (Start pulse) -> two-row READOUT -> IDLE.
// Outputs decode only registered state, so they are glitch-free with no input-to-output path.
module fsm_ex_control #(
  parameter int NRE_LOW = 3,
  parameter int ADC_POS = 1,
  parameter int GAP     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_i,
  input  logic ovf5_i,
  output logic nre1_o,
  output logic nre2_o,
  output logic adc_o,
  output logic expose_o,
  output logic erase_o,
  output logic start_o
);

  localparam int TOTAL = 2 * (NRE_LOW + GAP);
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [CW-1:0] C_LAST   = CW'(TOTAL - 1);
  localparam logic [CW-1:0] C_R1_END = CW'(NRE_LOW);
  localparam logic [CW-1:0] C_ADC1   = CW'(ADC_POS);
  localparam logic [CW-1:0] C_R2     = CW'(NRE_LOW + GAP);
  localparam logic [CW-1:0] C_R2_END = CW'(2 * NRE_LOW + GAP);
  localparam logic [CW-1:0] C_ADC2   = CW'(NRE_LOW + GAP + ADC_POS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXPOSE  = 2'd1,
    S_READOUT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            start_q, start_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  // Counter stays at zero outside READOUT, so every readout starts from c=0.
  always_comb begin
    state_d = S_IDLE;
    cnt_d   = '0;
    start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (init_i) begin
          state_d = S_EXPOSE;
          start_d = 1'b1;
        end
      end
      S_EXPOSE: begin
        state_d = ovf5_i ? S_READOUT : S_EXPOSE;
      end
      S_READOUT: begin
        if (cnt_q == C_LAST) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_READOUT;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    nre1_o   = 1'b1;
    nre2_o   = 1'b1;
    adc_o    = 1'b0;
    expose_o = 1'b0;
    erase_o  = 1'b1;
    start_o  = 1'b0;
    case (state_q)
      S_EXPOSE: begin
        erase_o  = 1'b0;
        expose_o = 1'b1;
        start_o  = start_q;
      end
      S_READOUT: begin
        erase_o = 1'b0;
        if (cnt_q < C_R1_END) begin
          nre1_o = 1'b0;
          adc_o  = (cnt_q == C_ADC1);
        end else if (cnt_q >= C_R2 && cnt_q < C_R2_END) begin
          nre2_o = 1'b0;
          adc_o  = (cnt_q == C_ADC2);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fsm_ex_control.sv
// Directed bench for fsm_ex_control: vector table plus hand-written multi-cycle sequences.
`timescale 1ms/1us
module tb_fsm_ex_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_i = 1'b0;
  logic ovf5_i = 1'b0;
  logic nre1_o, nre2_o, adc_o, expose_o, erase_o, start_o;

  int checks = 0;
  int failures = 0;

  always #1 clk = ~clk;

  fsm_ex_control dut (
    .clk(clk), .rst_n(rst_n), .init_i(init_i), .ovf5_i(ovf5_i),
    .nre1_o(nre1_o), .nre2_o(nre2_o), .adc_o(adc_o),
    .expose_o(expose_o), .erase_o(erase_o), .start_o(start_o)
  );

  // {nre1, nre2, adc, expose, erase, start}
  localparam logic [5:0] O_IDLE = 6'b110010;
  localparam logic [5:0] O_EXP1 = 6'b110101;
  localparam logic [5:0] O_EXPN = 6'b110100;
  localparam logic [5:0] O_R1   = 6'b010000;
  localparam logic [5:0] O_R1A  = 6'b011000;
  localparam logic [5:0] O_GAP  = 6'b110000;
  localparam logic [5:0] O_R2   = 6'b100000;
  localparam logic [5:0] O_R2A  = 6'b101000;

  typedef struct {
    logic       init;
    logic       ovf;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[15];
  logic [5:0] rd_seq[8];

  function automatic logic [5:0] outs();
    return {nre1_o, nre2_o, adc_o, expose_o, erase_o, start_o};
  endfunction

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (nre1 nre2 adc expose erase start)", name, act, exp);
    end
    checks++;
    if ((!nre1_o && !nre2_o) || (adc_o && nre1_o && nre2_o)) begin
      failures++;
      $display("FAIL %s_strobe_rule: got %b expected NRE exclusive and ADC within NRE low", name, act);
    end
  endtask

  // Called at a negedge: drive, cross one rising edge, release, leave at the next negedge.
  task automatic step(input logic init, input logic ovf);
    init_i = init;
    ovf5_i = ovf;
    @(posedge clk);
    @(negedge clk);
    init_i = 1'b0;
    ovf5_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, O_IDLE, "idle_ovf_ignored"};
    vecs[1]  = '{1'b1, 1'b0, O_EXP1, "expose_start"};
    vecs[2]  = '{1'b0, 1'b0, O_EXPN, "expose_hold"};
    vecs[3]  = '{1'b1, 1'b0, O_EXPN, "expose_init_ignored"};
    vecs[4]  = '{1'b0, 1'b1, O_R1,   "rd_c0"};
    vecs[5]  = '{1'b1, 1'b0, O_R1A,  "rd_c1_init_ignored"};
    vecs[6]  = '{1'b0, 1'b1, O_R1,   "rd_c2_ovf_ignored"};
    vecs[7]  = '{1'b0, 1'b0, O_GAP,  "rd_c3_gap"};
    vecs[8]  = '{1'b0, 1'b0, O_R2,   "rd_c4"};
    vecs[9]  = '{1'b0, 1'b0, O_R2A,  "rd_c5_adc"};
    vecs[10] = '{1'b0, 1'b0, O_R2,   "rd_c6"};
    vecs[11] = '{1'b0, 1'b0, O_GAP,  "rd_c7_gap"};
    vecs[12] = '{1'b0, 1'b1, O_IDLE, "back_idle"};
    vecs[13] = '{1'b1, 1'b1, O_EXP1, "init_ovf_same_edge"};
    vecs[14] = '{1'b0, 1'b1, O_R1,   "ovf_first_expose_cycle"};
    rd_seq = '{O_R1, O_R1A, O_R1, O_GAP, O_R2, O_R2A, O_R2, O_GAP};

    // Reset state
    #0.5;
    check("reset_held", O_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_released", O_IDLE);

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].init, vecs[i].ovf);
      check(vecs[i].name, vecs[i].exp);
    end
    // Finish the readout started by the last vector.
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b0);
      check($sformatf("rd2_c%0d", i), rd_seq[i]);
    end
    step(1'b0, 1'b0);
    check("rd2_done_idle", O_IDLE);

    // Long exposure: 15 cycles of Expose, Ovf5 30 ms after Start.
    step(1'b1, 1'b0);
    check("long_exp_start", O_EXP1);
    for (int i = 1; i < 15; i++) begin
      step(1'b0, 1'b0);
      check($sformatf("long_exp_%0d", i), O_EXPN);
    end
    for (int i = 0; i < 8; i++) begin
      step(i == 0, i == 0 ? 1'b1 : 1'b0);
      check($sformatf("long_rd_c%0d", i), rd_seq[i]);
    end
    step(1'b0, 1'b0);
    check("long_rd_done", O_IDLE);

    // Asynchronous reset while NRE_2 is low.
    step(1'b1, 1'b0);
    check("ar_start", O_EXP1);
    step(1'b0, 1'b1);
    for (int i = 1; i < 5; i++) step(1'b0, 1'b0);
    check("ar_pre_c4", O_R2);
    #0.5 rst_n = 1'b0;
    #0.1 check("ar_async_reset", O_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    check("ar_idle_after", O_IDLE);
    step(1'b1, 1'b0);
    check("ar_fresh_start", O_EXP1);
    step(1'b0, 1'b0);
    check("ar_fresh_hold", O_EXPN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
